// File: rtl/vga_fetch_sched.sv
// Fetch scheduler for the 2-bpp ping-pong pixel decoder.
// Issues one BRAM word read per 16 displayed pixels from the VGA counters,
// pulses the decoder back-buffer load, swaps front/back on word boundaries
// and grants every spare RAM cycle to the spectrum writer.
module vga_fetch_sched #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 15,
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  parameter int PRE_H    = 796
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic              buf_load,
  output logic              buf_sel,
  output logic [3:0]        pix_idx,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              wr_ack
);

  localparam int WPL = H_ACTIVE / 16;

  typedef enum logic [1:0] {IDLE, PRE, ACTIVE} state_t;

  state_t            state_q;
  logic              buf_load_q;
  logic              buf_sel_q;
  logic [ADDR_W-1:0] cur_base_q;   // base of the line being streamed
  logic [ADDR_W-1:0] nb_q;         // base of next_line, tracked incrementally
  logic [9:0]        tl_q;         // line number nb_q currently corresponds to

  logic [9:0]        next_line;
  logic              prefetch;
  logic              line_run;
  logic              inline_fetch;
  logic              fetch;
  logic              grant;
  logic              swap;
  logic [ADDR_W-1:0] fetch_addr;

  // Decode fetch slots, buffer swaps and writer grant from the timing counters
  always_comb begin
    next_line    = (vcount == 10'(V_TOTAL - 1)) ? '0 : vcount + 10'd1;
    prefetch     = (hcount == 10'(PRE_H)) && (next_line < 10'(V_ACTIVE));
    line_run     = (state_q == ACTIVE) || ((state_q == PRE) && (hcount == '0));
    inline_fetch = line_run && (vcount < 10'(V_ACTIVE)) &&
                   (hcount < 10'(H_ACTIVE - 16)) && (hcount[3:0] == 4'd0);
    fetch        = !reset && (prefetch || inline_fetch);
    grant        = !reset && !fetch && wr_req;
    swap         = ((state_q == PRE) && (hcount == 10'(H_TOTAL - 1))) ||
                   ((state_q == ACTIVE) && (hcount[3:0] == 4'hF) &&
                    (hcount < 10'(H_ACTIVE - 16)));
    fetch_addr   = prefetch ? nb_q
                            : cur_base_q + ADDR_W'(hcount[9:4]) + ADDR_W'(1);
  end

  // Drive the single BRAM port: fetch first, otherwise the writer
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    wr_ack    = 1'b0;
    if (fetch) begin
      mem_addr = fetch_addr;
    end else if (grant) begin
      mem_addr  = wr_addr;
      mem_we    = 1'b1;
      mem_wdata = wr_data;
      wr_ack    = 1'b1;
    end
    pix_idx = reset ? '0 : hcount[3:0];
  end

  assign buf_load = buf_load_q;
  assign buf_sel  = buf_sel_q;

  // Line-fetch FSM with registered decoder strobes; a prefetch (re)arms the
  // line from any state so a mid-line reset resumes cleanly at the next line
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      buf_load_q <= 1'b0;
      buf_sel_q  <= 1'b0;
      cur_base_q <= '0;
    end else begin
      buf_load_q <= fetch;
      if (swap) buf_sel_q <= ~buf_sel_q;
      if (prefetch) begin
        state_q    <= PRE;
        cur_base_q <= nb_q;
      end else begin
        case (state_q)
          PRE:     if ((hcount == '0) && (vcount < 10'(V_ACTIVE))) state_q <= ACTIVE;
          ACTIVE:  if (hcount == 10'(H_ACTIVE)) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // next_line * WPL without a multiplier: step one line per cycle towards
  // next_line and restart from 0 on frame wrap, so the base re-converges
  // within a line after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      tl_q <= '0;
      nb_q <= '0;
    end else if ((next_line == '0) || (next_line < tl_q)) begin
      tl_q <= '0;
      nb_q <= '0;
    end else if ((tl_q < next_line) && (tl_q < 10'(V_ACTIVE))) begin
      tl_q <= tl_q + 10'd1;
      nb_q <= nb_q + ADDR_W'(WPL);
    end
  end

endmodule

// File: tb/tb_vga_fetch_sched.sv
// Directed bench for vga_fetch_sched: table of single-cycle vectors plus
// hand sequences for frame start, writer stall, vblank burst and mid-line reset.
module tb_vga_fetch_sched;

  localparam int HT    = 800;
  localparam int VT    = 525;
  localparam int FRAME = HT * VT;

  logic        clk;
  logic        reset;
  logic [9:0]  hc, vc;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        buf_load, buf_sel;
  logic [3:0]  pix_idx;
  logic        wr_req;
  logic [14:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_ack;

  int checks = 0;
  int errors = 0;

  vga_fetch_sched #(
    .WIDTH(32), .ADDR_W(15), .H_ACTIVE(640), .H_TOTAL(800),
    .V_ACTIVE(480), .V_TOTAL(525), .PRE_H(796)
  ) dut (
    .clk(clk), .reset(reset), .hcount(hc), .vcount(vc),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .buf_load(buf_load), .buf_sel(buf_sel), .pix_idx(pix_idx),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          v;
    int          h;
    logic        req;
    logic [14:0] waddr;
    logic [31:0] wdata;
    logic [14:0] eaddr;
    logic        ewe;
    logic        eack;
    logic        eload;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at v=%0d h=%0d: got %0h expected %0h", name, vc, hc, act, exp);
    end
  endtask

  // advance one pixel; inputs change 1 time unit after the active edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (hc == 10'(HT - 1)) begin
      hc = '0;
      vc = (vc == 10'(VT - 1)) ? '0 : vc + 10'd1;
    end else begin
      hc = hc + 10'd1;
    end
  endtask

  task automatic set_pos(input int lin);
    @(posedge clk);
    #1;
    vc = 10'(lin / HT);
    hc = 10'(lin % HT);
  endtask

  // run forward to (v,h); far targets are approached from 1400 pixels earlier
  task automatic run_to(input int v, input int h);
    int cur, tgt, d;
    cur = int'(vc) * HT + int'(hc);
    tgt = v * HT + h;
    d = (tgt - cur + FRAME) % FRAME;
    if (d == 0 || d > 1400) begin
      set_pos((tgt + FRAME - 1400) % FRAME);
      d = 1400;
    end
    repeat (d) tick();
  endtask

  initial begin
    int n_load, n_ack;

    tbl[0]  = '{524, 796, 1'b1, 15'h0100, 32'h1,         15'd0,     1'b0, 1'b0, 1'b0};
    tbl[1]  = '{524, 797, 1'b0, 15'h0,    32'h0,         15'd0,     1'b0, 1'b0, 1'b1};
    tbl[2]  = '{0,   0,   1'b0, 15'h0,    32'h0,         15'd1,     1'b0, 1'b0, 1'b0};
    tbl[3]  = '{0,   1,   1'b0, 15'h0,    32'h0,         15'd0,     1'b0, 1'b0, 1'b1};
    tbl[4]  = '{0,   16,  1'b0, 15'h0,    32'h0,         15'd2,     1'b0, 1'b0, 1'b0};
    tbl[5]  = '{0,   608, 1'b0, 15'h0,    32'h0,         15'd39,    1'b0, 1'b0, 1'b0};
    tbl[6]  = '{0,   609, 1'b0, 15'h0,    32'h0,         15'd0,     1'b0, 1'b0, 1'b1};
    tbl[7]  = '{0,   624, 1'b0, 15'h0,    32'h0,         15'd0,     1'b0, 1'b0, 1'b0};
    tbl[8]  = '{0,   625, 1'b0, 15'h0,    32'h0,         15'd0,     1'b0, 1'b0, 1'b0};
    tbl[9]  = '{4,   796, 1'b0, 15'h0,    32'h0,         15'd200,   1'b0, 1'b0, 1'b0};
    tbl[10] = '{479, 608, 1'b0, 15'h0,    32'h0,         15'd19199, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{479, 796, 1'b1, 15'h0055, 32'h12345678,  15'h0055,  1'b1, 1'b1, 1'b0};
    tbl[12] = '{100, 8,   1'b1, 15'h7FFF, 32'hA5A50F0F,  15'h7FFF,  1'b1, 1'b1, 1'b0};
    tbl[13] = '{100, 32,  1'b1, 15'h0010, 32'h0BADF00D,  15'd4003,  1'b0, 1'b0, 1'b0};
    tbl[14] = '{200, 796, 1'b1, 15'h0011, 32'h0,         15'd8040,  1'b0, 1'b0, 1'b0};

    // reset: every output low while reset is held
    reset = 1'b1; hc = 10'd5; vc = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (2) @(posedge clk);
    #4;
    chk("reset_outputs", {mem_addr, mem_we, mem_wdata, buf_load, buf_sel, pix_idx, wr_ack}, '0);

    // frame start from a fresh reset: prefetch, 40 loads, swap pattern
    set_pos(523 * HT + 600);
    reset = 1'b0;
    run_to(524, 796);
    #3;
    chk("frame_prefetch_addr", mem_addr, 64'd0);
    chk("frame_prefetch_we", mem_we, 64'd0);
    n_load = 0;
    for (int i = 0; i < 800; i++) begin
      tick();
      #3;
      if (buf_load) n_load++;
      if (vc == 10'd524 && hc == 10'd798) chk("sel_before_swap", buf_sel, 64'd0);
      if (vc == 10'd0 && hc == 10'd0)     chk("sel_h0", buf_sel, 64'd1);
      if (vc == 10'd0 && hc == 10'd15)    chk("sel_h15", buf_sel, 64'd1);
      if (vc == 10'd0 && hc == 10'd16)    chk("sel_h16", buf_sel, 64'd0);
      if (vc == 10'd0 && hc == 10'd37)    chk("pix_idx", pix_idx, 64'd5);
      if (vc == 10'd0 && hc == 10'd700)   chk("sel_hblank", buf_sel, 64'd0);
    end
    chk("loads_per_line", 64'(n_load), 64'd40);
    run_to(1, 0);
    #3;
    chk("sel_line1_h0", buf_sel, 64'd1);

    // table-driven single-cycle vectors
    for (int i = 0; i < 15; i++) begin
      run_to(tbl[i].v, tbl[i].h);
      wr_req = tbl[i].req; wr_addr = tbl[i].waddr; wr_data = tbl[i].wdata;
      #3;
      chk($sformatf("vec%0d_addr", i), mem_addr, 64'(tbl[i].eaddr));
      chk($sformatf("vec%0d_we", i), mem_we, 64'(tbl[i].ewe));
      chk($sformatf("vec%0d_ack", i), wr_ack, 64'(tbl[i].eack));
      chk($sformatf("vec%0d_load", i), buf_load, 64'(tbl[i].eload));
      if (tbl[i].ewe) chk($sformatf("vec%0d_wdata", i), mem_wdata, 64'(tbl[i].wdata));
      wr_req = 1'b0;
    end

    // writer held across a fetch: stalls at 16, granted at 17
    run_to(2, 16);
    wr_req = 1'b1; wr_addr = 15'h1234; wr_data = 32'hDEADBEEF;
    #3;
    chk("stall_ack", wr_ack, 64'd0);
    chk("stall_we", mem_we, 64'd0);
    chk("stall_fetch_addr", mem_addr, 64'd82);
    tick();
    #3;
    chk("grant_ack", wr_ack, 64'd1);
    chk("grant_we", mem_we, 64'd1);
    chk("grant_addr", mem_addr, 64'h1234);
    chk("grant_wdata", mem_wdata, 64'hDEADBEEF);
    wr_req = 1'b0;

    // vblank burst: every cycle granted, no loads
    run_to(500, 0);
    n_load = 0; n_ack = 0;
    for (int i = 0; i < 100; i++) begin
      wr_req = 1'b1; wr_addr = 15'(i); wr_data = 32'(i);
      #3;
      if (wr_ack) n_ack++;
      if (buf_load) n_load++;
      tick();
    end
    wr_req = 1'b0;
    chk("burst_acks", 64'(n_ack), 64'd100);
    chk("burst_loads", 64'(n_load), 64'd0);

    // mid-line reset: outputs clear, no fetch until the line-11 prefetch
    run_to(10, 300);
    reset = 1'b1;
    #3;
    tick();
    reset = 1'b0;
    #3;
    chk("midreset_outputs", {mem_addr, mem_we, buf_load, buf_sel, wr_ack}, '0);
    n_load = 0;
    for (int i = 0; i < 495; i++) begin
      tick();
      #3;
      if (buf_load) n_load++;
    end
    chk("midreset_no_loads", 64'(n_load), 64'd0);
    chk("midreset_prefetch_addr", mem_addr, 64'd440);
    chk("midreset_prefetch_we", mem_we, 64'd0);
    tick();
    #3;
    chk("midreset_prefetch_load", buf_load, 64'd1);
    run_to(11, 0);
    #3;
    chk("line11_word1_addr", mem_addr, 64'd441);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
